// File: rtl/design_switcher_if.sv
// Pad bus bundle between the per-design fabric and the shared pads.
// Every signal here is a level-valued bus with no valid/ready handshake.
// A value is meaningful on every cycle, and the switcher samples or drives it continuously.
interface design_switcher_if #(
    parameter int N_DESIGNS = 8,
    parameter int IO_W      = 42
);
    // Per-design pad controls; slot i sits at bits [i*IO_W +: IO_W]
    logic [N_DESIGNS*IO_W-1:0] dsn_out_i;
    logic [N_DESIGNS*IO_W-1:0] dsn_oe_i;
    logic [N_DESIGNS*IO_W-1:0] dsn_pu_i;
    logic [N_DESIGNS*IO_W-1:0] dsn_pd_i;
    logic [N_DESIGNS*IO_W-1:0] dsn_cs_i;

    // Muxed pad drive
    logic [IO_W-1:0] io_out;
    logic [IO_W-1:0] io_oe;
    logic [IO_W-1:0] io_pu;
    logic [IO_W-1:0] io_pd;
    logic [IO_W-1:0] io_cs;

    // Fabric side: supplies per-design controls, observes the pads
    modport master (
        output dsn_out_i, dsn_oe_i, dsn_pu_i, dsn_pd_i, dsn_cs_i,
        input  io_out, io_oe, io_pu, io_pd, io_cs
    );

    // Switcher side: consumes per-design controls, drives the pads
    modport slave (
        input  dsn_out_i, dsn_oe_i, dsn_pu_i, dsn_pd_i, dsn_cs_i,
        output io_out, io_oe, io_pu, io_pd, io_cs
    );
endinterface

// File: rtl/design_switcher.sv
// Pad-sharing design switcher.
// The pad selector is synchronised and debounced before use.
// A change of design then runs as a RUN -> QUIESCE -> HOLD -> RUN sequence.
// Pads are forced safe while QUIESCE is active.
// The newly selected design is held in reset through HOLD.
module design_switcher #(
    parameter int              N_DESIGNS   = 8,
    parameter int              SEL_W       = 3,
    parameter int              IO_W        = 42,
    parameter int              STABLE_CYC  = 16,
    parameter int              QUIESCE_CYC = 4,
    parameter int              HOLD_CYC    = 8,
    parameter logic [IO_W-1:0] SAFE_OE     = {IO_W{1'b1}}
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 ext_rst_n_i,
    input  logic [SEL_W-1:0]     design_sel_i,
    design_switcher_if.slave     bus,
    output logic [N_DESIGNS-1:0] dsn_rst_n_o,
    output logic [SEL_W-1:0]     active_sel_o,
    output logic                 switching_o,
    output logic [1:0]           dbg_state_o
);
    localparam int CNT_W  = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int PH_MAX = (QUIESCE_CYC > HOLD_CYC) ? QUIESCE_CYC : HOLD_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
    localparam logic [PH_W-1:0]  Q_LOAD  = PH_W'(QUIESCE_CYC - 1);
    localparam logic [PH_W-1:0]  H_LOAD  = PH_W'(HOLD_CYC - 1);
    localparam logic [SEL_W:0]   N_SLOTS = (SEL_W + 1)'(N_DESIGNS);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    logic [SEL_W-1:0]     sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic                 ext_s1_q, ext_s1_d, ext_s2_q, ext_s2_d;
    logic [SEL_W-1:0]     cand_q, cand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    state_e               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [SEL_W-1:0]     active_sel_q, active_sel_d;
    logic [N_DESIGNS-1:0] dsn_rst_n_q, dsn_rst_n_d;
    logic                 stable;
    logic [SEL_W-1:0]     cand_eff;

    // Next-state: synchronisers, debouncer, switch sequencer, per-design resets
    always_comb begin
        sel_s1_d     = design_sel_i;
        sel_s2_d     = sel_s1_q;
        ext_s1_d     = ext_rst_n_i;
        ext_s2_d     = ext_s1_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        state_d      = state_q;
        phase_d      = phase_q;
        active_sel_d = active_sel_q;
        dsn_rst_n_d  = '0;

        stable   = (cnt_q == CNT_MAX);
        // Selector codes with no design behind them fall back to "no design"
        cand_eff = ({1'b0, cand_q} >= N_SLOTS) ? '0 : cand_q;

        // Any movement of the selector restarts the stability window
        if (sel_s2_q != cand_q) begin
            cand_d = sel_s2_q;
            cnt_d  = '0;
        end else if (!stable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Once started, a switch always runs to completion
        case (state_q)
            ST_RUN: begin
                if (stable && (cand_eff != active_sel_q)) begin
                    state_d = ST_QUIESCE;
                    phase_d = Q_LOAD;
                end
            end
            ST_QUIESCE: begin
                if (phase_q == '0) begin
                    state_d      = ST_HOLD;
                    active_sel_d = cand_eff;
                    phase_d      = H_LOAD;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            ST_HOLD: begin
                if (phase_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                phase_d = '0;
            end
        endcase

        // Only the design running in RUN leaves reset, and slot 0 never does
        for (int i = 1; i < N_DESIGNS; i++) begin
            dsn_rst_n_d[i] = (state_d == ST_RUN) && (active_sel_d == SEL_W'(i)) && ext_s2_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            sel_s1_q     <= '0;
            sel_s2_q     <= '0;
            ext_s1_q     <= 1'b0;
            ext_s2_q     <= 1'b0;
            cand_q       <= '0;
            cnt_q        <= '0;
            state_q      <= ST_RUN;
            phase_q      <= '0;
            active_sel_q <= '0;
            dsn_rst_n_q  <= '0;
        end else begin
            sel_s1_q     <= sel_s1_d;
            sel_s2_q     <= sel_s2_d;
            ext_s1_q     <= ext_s1_d;
            ext_s2_q     <= ext_s2_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            phase_q      <= phase_d;
            active_sel_q <= active_sel_d;
            dsn_rst_n_q  <= dsn_rst_n_d;
        end
    end

    // Pad mux: safe while quiescing or with no design selected, else the active slot
    always_comb begin
        bus.io_out = '0;
        bus.io_oe  = SAFE_OE;
        bus.io_pu  = '0;
        bus.io_pd  = '0;
        bus.io_cs  = '0;
        if ((state_q != ST_QUIESCE) && (active_sel_q != '0)) begin
            for (int i = 1; i < N_DESIGNS; i++) begin
                if (active_sel_q == SEL_W'(i)) begin
                    bus.io_out = bus.dsn_out_i[i*IO_W +: IO_W];
                    bus.io_oe  = bus.dsn_oe_i[i*IO_W +: IO_W];
                    bus.io_pu  = bus.dsn_pu_i[i*IO_W +: IO_W];
                    bus.io_pd  = bus.dsn_pd_i[i*IO_W +: IO_W];
                    bus.io_cs  = bus.dsn_cs_i[i*IO_W +: IO_W];
                end
            end
        end
    end

    assign dsn_rst_n_o  = dsn_rst_n_q;
    assign active_sel_o = active_sel_q;
    assign switching_o  = (state_q == ST_QUIESCE) || (state_q == ST_HOLD);
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_design_switcher.sv
// Directed bench for design_switcher.
// u_dut8 uses the default 8-slot configuration.
// u_dut6 has 6 slots, so that out-of-range selector codes can be exercised.
module tb_design_switcher;
    localparam int IO_W  = 42;
    localparam int SEL_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             ext_rst_n;
    logic [SEL_W-1:0] sel8;
    logic [SEL_W-1:0] sel6;

    logic [IO_W-1:0] slot_out [8];
    logic [IO_W-1:0] slot_oe  [8];
    logic [IO_W-1:0] slot_pu  [8];
    logic [IO_W-1:0] slot_pd  [8];
    logic [IO_W-1:0] slot_cs  [8];

    design_switcher_if #(.N_DESIGNS(8), .IO_W(IO_W)) bus8 ();
    design_switcher_if #(.N_DESIGNS(6), .IO_W(IO_W)) bus6 ();

    logic [7:0]       dsn_rst8;
    logic [SEL_W-1:0] act8;
    logic             sw8;
    logic [1:0]       st8;
    logic [5:0]       dsn_rst6;
    logic [SEL_W-1:0] act6;
    logic             sw6;
    logic [1:0]       st6;

    // Pack the per-slot tables onto both fabrics
    always_comb begin
        bus8.dsn_out_i = '0;
        bus8.dsn_oe_i  = '0;
        bus8.dsn_pu_i  = '0;
        bus8.dsn_pd_i  = '0;
        bus8.dsn_cs_i  = '0;
        for (int i = 0; i < 8; i++) begin
            bus8.dsn_out_i[i*IO_W +: IO_W] = slot_out[i];
            bus8.dsn_oe_i[i*IO_W +: IO_W]  = slot_oe[i];
            bus8.dsn_pu_i[i*IO_W +: IO_W]  = slot_pu[i];
            bus8.dsn_pd_i[i*IO_W +: IO_W]  = slot_pd[i];
            bus8.dsn_cs_i[i*IO_W +: IO_W]  = slot_cs[i];
        end
    end

    always_comb begin
        bus6.dsn_out_i = '0;
        bus6.dsn_oe_i  = '0;
        bus6.dsn_pu_i  = '0;
        bus6.dsn_pd_i  = '0;
        bus6.dsn_cs_i  = '0;
        for (int i = 0; i < 6; i++) begin
            bus6.dsn_out_i[i*IO_W +: IO_W] = slot_out[i];
            bus6.dsn_oe_i[i*IO_W +: IO_W]  = slot_oe[i];
            bus6.dsn_pu_i[i*IO_W +: IO_W]  = slot_pu[i];
            bus6.dsn_pd_i[i*IO_W +: IO_W]  = slot_pd[i];
            bus6.dsn_cs_i[i*IO_W +: IO_W]  = slot_cs[i];
        end
    end

    design_switcher #(
        .N_DESIGNS(8), .SEL_W(SEL_W), .IO_W(IO_W),
        .STABLE_CYC(16), .QUIESCE_CYC(4), .HOLD_CYC(8)
    ) u_dut8 (
        .clk_i(clk), .rst_n(rst_n), .ext_rst_n_i(ext_rst_n), .design_sel_i(sel8),
        .bus(bus8.slave), .dsn_rst_n_o(dsn_rst8), .active_sel_o(act8),
        .switching_o(sw8), .dbg_state_o(st8)
    );

    design_switcher #(
        .N_DESIGNS(6), .SEL_W(SEL_W), .IO_W(IO_W),
        .STABLE_CYC(16), .QUIESCE_CYC(4), .HOLD_CYC(8)
    ) u_dut6 (
        .clk_i(clk), .rst_n(rst_n), .ext_rst_n_i(ext_rst_n), .design_sel_i(sel6),
        .bus(bus6.slave), .dsn_rst_n_o(dsn_rst6), .active_sel_o(act6),
        .switching_o(sw6), .dbg_state_o(st6)
    );

    // Scoreboard
    logic [63:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic expect_v(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_v(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts edges until switching_o of u_dut8 reaches lvl, giving up after max
    task automatic wait_sw(input logic lvl, input int max, output int n);
        n = 0;
        while ((sw8 !== lvl) && (n < max)) begin
            step(1);
            n++;
        end
    endtask

    // Slot 0 means the safe pad state
    task automatic chk_pads(input string tag, input int slot,
                            input logic [IO_W-1:0] o, input logic [IO_W-1:0] oe,
                            input logic [IO_W-1:0] pu, input logic [IO_W-1:0] pd,
                            input logic [IO_W-1:0] cs);
        logic [IO_W-1:0] all1;
        all1 = '1;
        if (slot == 0) begin
            expect_v(64'(0));
            expect_v(64'(all1));
            expect_v(64'(0));
            expect_v(64'(0));
            expect_v(64'(0));
        end else begin
            expect_v(64'(slot_out[slot]));
            expect_v(64'(slot_oe[slot]));
            expect_v(64'(slot_pu[slot]));
            expect_v(64'(slot_pd[slot]));
            expect_v(64'(slot_cs[slot]));
        end
        check_v({tag, "_out"}, 64'(o));
        check_v({tag, "_oe"}, 64'(oe));
        check_v({tag, "_pu"}, 64'(pu));
        check_v({tag, "_pd"}, 64'(pd));
        check_v({tag, "_cs"}, 64'(cs));
    endtask

    int         n;
    logic       saw_sw;
    logic       saw_bad;
    logic [9:0] trace;

    initial begin
        for (int i = 0; i < 8; i++) begin
            slot_out[i] = IO_W'({$urandom(), $urandom()});
            slot_oe[i]  = IO_W'({$urandom(), $urandom()});
            slot_pu[i]  = IO_W'({$urandom(), $urandom()});
            slot_pd[i]  = IO_W'({$urandom(), $urandom()});
            slot_cs[i]  = IO_W'({$urandom(), $urandom()});
        end
        rst_n     = 1'b0;
        ext_rst_n = 1'b1;
        sel8      = 3'd3;
        sel6      = 3'd7;
        step(3);

        // Reset state
        expect_v(0); check_v("rst_switching", 64'(sw8));
        expect_v(0); check_v("rst_active", 64'(act8));
        expect_v(0); check_v("rst_dsn_rst", 64'(dsn_rst8));
        expect_v(0); check_v("rst_state", 64'(st8));
        chk_pads("rst_pads", 0, bus8.io_out, bus8.io_oe, bus8.io_pu, bus8.io_pd, bus8.io_cs);

        // First switch to slot 3 after reset release
        rst_n = 1'b1;
        wait_sw(1'b1, 40, n);
        expect_v(19); check_v("first_rise_edge", 64'(n));
        expect_v(0);  check_v("quiesce_active", 64'(act8));
        chk_pads("quiesce_pads", 0, bus8.io_out, bus8.io_oe, bus8.io_pu, bus8.io_pd, bus8.io_cs);
        step(4);
        expect_v(3); check_v("hold_active", 64'(act8));
        expect_v(0); check_v("hold_dsn_rst", 64'(dsn_rst8));
        chk_pads("hold_pads", 3, bus8.io_out, bus8.io_oe, bus8.io_pu, bus8.io_pd, bus8.io_cs);
        wait_sw(1'b0, 20, n);
        expect_v(8);        check_v("hold_len", 64'(n));
        expect_v(64'h08);   check_v("run3_dsn_rst", 64'(dsn_rst8));
        expect_v(3);        check_v("run3_active", 64'(act8));
        chk_pads("run3_pads", 3, bus8.io_out, bus8.io_oe, bus8.io_pu, bus8.io_pd, bus8.io_cs);

        // Out-of-range selector on the 6-slot instance
        expect_v(0); check_v("d6_oor_active", 64'(act6));
        expect_v(0); check_v("d6_oor_switching", 64'(sw6));
        expect_v(0); check_v("d6_oor_dsn_rst", 64'(dsn_rst6));
        chk_pads("d6_oor_pads", 0, bus6.io_out, bus6.io_oe, bus6.io_pu, bus6.io_pd, bus6.io_cs);

        // Short glitch to 5 is filtered
        sel8    = 3'd5;
        sel6    = 3'd5;
        saw_sw  = 1'b0;
        saw_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            saw_sw  = saw_sw | sw8;
            saw_bad = saw_bad | ~dsn_rst8[3];
        end
        sel8 = 3'd3;
        for (int k = 0; k < 40; k++) begin
            step(1);
            saw_sw  = saw_sw | sw8;
            saw_bad = saw_bad | ~dsn_rst8[3];
        end
        expect_v(0); check_v("glitch_switching", 64'(saw_sw));
        expect_v(0); check_v("glitch_rst_drop", 64'(saw_bad));
        expect_v(3); check_v("glitch_active", 64'(act8));
        expect_v(5);       check_v("d6_slot5_active", 64'(act6));
        expect_v(64'h20);  check_v("d6_slot5_dsn_rst", 64'(dsn_rst6));
        chk_pads("d6_slot5_pads", 5, bus6.io_out, bus6.io_oe, bus6.io_pu, bus6.io_pd, bus6.io_cs);

        // Switch to 5, change to 6 during HOLD, then a second switch lands on 6
        sel8 = 3'd5;
        sel6 = 3'd7;
        wait_sw(1'b1, 40, n);
        expect_v(19); check_v("sw5_rise_edge", 64'(n));
        chk_pads("sw5_quiesce_pads", 0, bus8.io_out, bus8.io_oe, bus8.io_pu, bus8.io_pd, bus8.io_cs);
        step(4);
        expect_v(5); check_v("sw5_hold_active", 64'(act8));
        sel8 = 3'd6;
        wait_sw(1'b0, 20, n);
        expect_v(8);      check_v("sw5_hold_len", 64'(n));
        expect_v(5);      check_v("sw5_run_active", 64'(act8));
        expect_v(64'h20); check_v("sw5_run_dsn_rst", 64'(dsn_rst8));
        wait_sw(1'b1, 40, n);
        expect_v(11); check_v("sw6_rise_edge", 64'(n));
        step(4);
        expect_v(6); check_v("sw6_hold_active", 64'(act8));
        wait_sw(1'b0, 20, n);
        expect_v(8);      check_v("sw6_hold_len", 64'(n));
        expect_v(64'h40); check_v("sw6_dsn_rst", 64'(dsn_rst8));
        chk_pads("sw6_pads", 6, bus8.io_out, bus8.io_oe, bus8.io_pu, bus8.io_pd, bus8.io_cs);
        expect_v(0); check_v("d6_back0_active", 64'(act6));
        expect_v(0); check_v("d6_back0_dsn_rst", 64'(dsn_rst6));
        chk_pads("d6_back0_pads", 0, bus6.io_out, bus6.io_oe, bus6.io_pu, bus6.io_pd, bus6.io_cs);

        // Switch to slot 2, then pulse the pad reset for 5 cycles
        sel8 = 3'd2;
        wait_sw(1'b1, 40, n);
        expect_v(19); check_v("sw2_rise_edge", 64'(n));
        step(4);
        wait_sw(1'b0, 20, n);
        expect_v(8);      check_v("sw2_hold_len", 64'(n));
        expect_v(64'h04); check_v("sw2_dsn_rst", 64'(dsn_rst8));
        ext_rst_n = 1'b0;
        saw_bad   = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            trace[k-1] = dsn_rst8[2];
            if ((bus8.io_out !== slot_out[2]) || (act8 !== 3'd2) || (sw8 !== 1'b0)) saw_bad = 1'b1;
            if (k == 4) slot_out[2] = IO_W'({$urandom(), $urandom()});
            if (k == 5) ext_rst_n = 1'b1;
        end
        expect_v(64'(10'b11_1000_0011)); check_v("ext_rst_trace", 64'(trace));
        expect_v(0);                     check_v("ext_rst_mux_disturbed", 64'(saw_bad));
        expect_v(64'h04);                check_v("ext_rst_recovered", 64'(dsn_rst8));

        // Reset asserted mid-HOLD abandons the sequence
        sel8 = 3'd4;
        wait_sw(1'b1, 40, n);
        expect_v(19); check_v("sw4_rise_edge", 64'(n));
        step(4);
        expect_v(4); check_v("sw4_hold_active", 64'(act8));
        step(2);
        rst_n = 1'b0;
        step(1);
        expect_v(0); check_v("midhold_rst_switching", 64'(sw8));
        expect_v(0); check_v("midhold_rst_active", 64'(act8));
        expect_v(0); check_v("midhold_rst_dsn_rst", 64'(dsn_rst8));
        expect_v(0); check_v("midhold_rst_state", 64'(st8));
        chk_pads("midhold_rst_pads", 0, bus8.io_out, bus8.io_oe, bus8.io_pu, bus8.io_pd, bus8.io_cs);
        rst_n = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
